// File: rtl/otter_timer_pkg.sv
// Shared definitions for the OTTER I/O countdown timer: register offsets,
// CTRL bit positions and the timer state encoding.
package otter_timer_pkg;

  // Word offsets, matched against IOBUS_ADDR[3:2]
  localparam logic [1:0] TMR_CTRL   = 2'd0;
  localparam logic [1:0] TMR_RELOAD = 2'd1;
  localparam logic [1:0] TMR_COUNT  = 2'd2;
  localparam logic [1:0] TMR_STATUS = 2'd3;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_AUTO   = 1;
  localparam int CTRL_IE     = 2;
  localparam int CTRL_PS_LSB = 4;
  localparam int CTRL_PS_MSB = 11;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } tmr_state_t;

endpackage

// File: rtl/otter_intr_stretch.sv
// Registered interrupt pulse of INTR_CYCLES clocks; a retrigger while the
// pulse is active restarts the count, extending the pulse.
module otter_intr_stretch #(
  parameter int INTR_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic trigger,
  output logic pulse
);

  logic [3:0] remain;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; pulse below deliberately reads the old remain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      remain <= '0;
      pulse  <= 1'b0;
    end else begin
      if (trigger) begin
        remain <= 4'(INTR_CYCLES);
      end else if (remain != 4'd0) begin
        remain <= remain - 4'd1;
      end
      pulse <= trigger || (remain > 4'd1);
    end
  end

endmodule

// File: rtl/otter_io_timer.sv
// Memory-mapped countdown timer on the OTTER IOBUS with sticky expiry flag and
// stretched interrupt. Define OTTER_TIMER_PRESCALE_EN to build the prescaler.
module otter_io_timer
  import otter_timer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h1100_D000,
  parameter int          INTR_CYCLES = 4
) (
  input  logic        clk,
  input  logic        RST,
  input  logic [31:0] IOBUS_ADDR,
  input  logic [31:0] IOBUS_OUT,
  input  logic        IOBUS_WR,
  output logic [31:0] IOBUS_IN,
  output logic        INTR
);

  tmr_state_t  st, st_next;
  logic        ctrl_en, ctrl_auto, ctrl_ie;
  logic [31:0] reload, count;
  logic        exp_flag;
  logic [7:0]  prescale_rd;
  logic [1:0]  reg_sel;
  logic        sel, wr_hit, wr_ctrl, wr_reload, wr_count, wr_status;
  logic        ctrl_off_wr, tick, run_tick, expire, intr_trig;
  logic        unused_addr_bits;

  assign reg_sel          = IOBUS_ADDR[3:2];
  assign sel              = (IOBUS_ADDR[31:4] == BASE_ADDR[31:4]);
  assign wr_hit           = IOBUS_WR && sel;
  assign wr_ctrl          = wr_hit && (reg_sel == TMR_CTRL);
  assign wr_reload        = wr_hit && (reg_sel == TMR_RELOAD);
  assign wr_count         = wr_hit && (reg_sel == TMR_COUNT);
  assign wr_status        = wr_hit && (reg_sel == TMR_STATUS);
  assign ctrl_off_wr      = wr_ctrl && !IOBUS_OUT[CTRL_EN];
  assign unused_addr_bits = ^IOBUS_ADDR[1:0];

`ifdef OTTER_TIMER_PRESCALE_EN
  logic [7:0] prescale, ps_cnt;

  // >= keeps ticks coming if PRESCALE is lowered below the running prescaler
  assign tick        = (st == RUN) && (ps_cnt >= prescale);
  assign prescale_rd = prescale;

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      prescale <= '0;
      ps_cnt   <= '0;
    end else begin
      if (wr_ctrl) prescale <= IOBUS_OUT[CTRL_PS_MSB:CTRL_PS_LSB];
      if (st != RUN || ctrl_off_wr || tick) ps_cnt <= '0;
      else                                  ps_cnt <= ps_cnt + 8'd1;
    end
  end
`else
  assign tick        = (st == RUN);
  assign prescale_rd = '0;
`endif

  // A disabling CTRL write or a COUNT write in the same cycle beats the expiry
  assign run_tick  = tick && !ctrl_off_wr;
  assign expire    = run_tick && (count == 32'd1) && !wr_count;
  assign intr_trig = expire && ctrl_ie;

  always_ff @(posedge clk or posedge RST) begin
    if (RST) st <= IDLE;
    else     st <= st_next;
  end

  // NOTE: st_next gets its default before any branch so no latch is inferred.
  always_comb begin
    st_next = st;
    unique case (st)
      IDLE:    if (wr_ctrl && IOBUS_OUT[CTRL_EN])   st_next = RUN;
      RUN:     if (expire && !ctrl_auto)            st_next = DONE;
      DONE:    if (wr_count && (IOBUS_OUT != '0))   st_next = RUN;
      default:                                      st_next = IDLE;
    endcase
    if (ctrl_off_wr) st_next = IDLE;
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      ctrl_en   <= 1'b0;
      ctrl_auto <= 1'b0;
      ctrl_ie   <= 1'b0;
      reload    <= '0;
      count     <= '0;
      exp_flag  <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        ctrl_en   <= IOBUS_OUT[CTRL_EN];
        ctrl_auto <= IOBUS_OUT[CTRL_AUTO];
        ctrl_ie   <= IOBUS_OUT[CTRL_IE];
      end
      if (wr_reload) reload <= IOBUS_OUT;
      if (wr_count)                        count <= IOBUS_OUT;
      else if (expire && ctrl_auto)        count <= reload;
      else if (run_tick && count != '0)    count <= count - 32'd1;
      // Set beats a same-cycle clear
      if (expire)                          exp_flag <= 1'b1;
      else if (wr_status && IOBUS_OUT[0])  exp_flag <= 1'b0;
    end
  end

  always_comb begin
    IOBUS_IN = '0;
    if (sel) begin
      unique case (reg_sel)
        TMR_CTRL: begin
          IOBUS_IN[CTRL_EN]                 = ctrl_en;
          IOBUS_IN[CTRL_AUTO]               = ctrl_auto;
          IOBUS_IN[CTRL_IE]                 = ctrl_ie;
          IOBUS_IN[CTRL_PS_MSB:CTRL_PS_LSB] = prescale_rd;
        end
        TMR_RELOAD: IOBUS_IN    = reload;
        TMR_COUNT:  IOBUS_IN    = count;
        default:    IOBUS_IN[0] = exp_flag;
      endcase
    end
  end

  otter_intr_stretch #(
    .INTR_CYCLES(INTR_CYCLES)
  ) u_intr_stretch (
    .clk    (clk),
    .rst    (RST),
    .trigger(intr_trig),
    .pulse  (INTR)
  );

endmodule

// File: tb/tb_otter_io_timer.sv
// Self-checking bench for otter_io_timer: directed scenarios plus randomized
// bus traffic compared against a behavioural register/timer model.
module tb_otter_io_timer;
  import otter_timer_pkg::*;

  localparam logic [31:0] BASE = 32'h1100_D000;
  localparam int          ICYC = 4;
  localparam logic [31:0] A_CTRL   = BASE + 32'h0;
  localparam logic [31:0] A_RELOAD = BASE + 32'h4;
  localparam logic [31:0] A_COUNT  = BASE + 32'h8;
  localparam logic [31:0] A_STATUS = BASE + 32'hC;
`ifdef OTTER_TIMER_PRESCALE_EN
  localparam bit PS_EN = 1'b1;
`else
  localparam bit PS_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        RST = 1'b0;
  logic [31:0] IOBUS_ADDR = '0;
  logic [31:0] IOBUS_OUT = '0;
  logic        IOBUS_WR = 1'b0;
  logic [31:0] IOBUS_IN;
  logic        INTR;

  int n_checks = 0;
  int n_fail   = 0;

  otter_io_timer #(.BASE_ADDR(BASE), .INTR_CYCLES(ICYC)) dut (
    .clk       (clk),
    .RST       (RST),
    .IOBUS_ADDR(IOBUS_ADDR),
    .IOBUS_OUT (IOBUS_OUT),
    .IOBUS_WR  (IOBUS_WR),
    .IOBUS_IN  (IOBUS_IN),
    .INTR      (INTR)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  bit          m_en, m_auto, m_ie, m_exp;
  int          m_ps, m_phase, m_left, m_mode;  // mode: 0 off, 1 counting, 2 finished
  logic [31:0] m_reload, m_count;

  function automatic void m_reset();
    m_en = 0; m_auto = 0; m_ie = 0; m_exp = 0;
    m_ps = 0; m_phase = 0; m_left = 0; m_mode = 0;
    m_reload = '0; m_count = '0;
  endfunction

  function automatic bit m_intr();
    return m_left > 0;
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] addr);
    logic [31:0] v;
    v = '0;
    if (addr[31:4] == BASE[31:4]) begin
      case (addr[3:2])
        2'd0: v = {20'd0, 8'(m_ps), 1'b0, m_ie, m_auto, m_en};
        2'd1: v = m_reload;
        2'd2: v = m_count;
        default: v = {31'd0, m_exp};
      endcase
    end
    return v;
  endfunction

  function automatic void m_step(input logic wr, input logic [31:0] addr, input logic [31:0] data);
    bit hit, tick, off, cw, ev;
    int r, new_mode;
    hit  = wr && (addr[31:4] == BASE[31:4]);
    r    = int'(addr[3:2]);
    tick = (m_mode == 1) && (m_phase >= m_ps);
    off  = hit && (r == 0) && !data[0];
    cw   = hit && (r == 2);
    ev   = tick && !off && !cw && (m_count == 32'd1);

    if (ev && m_ie)      m_left = ICYC;
    else if (m_left > 0) m_left = m_left - 1;

    if (cw)                                   m_count = data;
    else if (ev && m_auto)                    m_count = m_reload;
    else if (tick && !off && m_count != '0)   m_count = m_count - 1;

    if (ev)                                   m_exp = 1;
    else if (hit && r == 3 && data[0])        m_exp = 0;

    if (m_mode == 1 && !off) m_phase = tick ? 0 : m_phase + 1;
    else                     m_phase = 0;

    new_mode = m_mode;
    if (off)                                             new_mode = 0;
    else if (m_mode == 0 && hit && r == 0 && data[0])    new_mode = 1;
    else if (m_mode == 1 && ev && !m_auto)               new_mode = 2;
    else if (m_mode == 2 && cw && data != '0)            new_mode = 1;
    m_mode = new_mode;

    if (hit && r == 0) begin
      m_en   = data[0];
      m_auto = data[1];
      m_ie   = data[2];
      m_ps   = PS_EN ? int'(data[11:4]) : 0;
    end
    if (hit && r == 1) m_reload = data;
  endfunction

  // ---------------- checking and stimulus ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=0x%08h want=0x%08h t=%0t", tag, got, want, $time);
    end
  endtask

  task automatic rd_want(input string tag, input logic [31:0] addr, input logic [31:0] want);
    IOBUS_ADDR = addr;
    #1;
    check(tag, IOBUS_IN, want);
  endtask

  // One bus cycle: caller sits at a negedge; returns at the next negedge
  task automatic cyc(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                     input logic [31:0] raddr);
    IOBUS_WR   = wr;
    IOBUS_ADDR = addr;
    IOBUS_OUT  = data;
    @(posedge clk);
    m_step(wr, addr, data);
    #1;
    IOBUS_WR = 1'b0;
    check("intr", INTR, m_intr());
    IOBUS_ADDR = raddr;
    #1;
    check("read", IOBUS_IN, m_read(raddr));
    @(negedge clk);
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    cyc(1'b1, addr, data, A_COUNT);
  endtask

  task automatic idle(input logic [31:0] raddr);
    cyc(1'b0, BASE, '0, raddr);
  endtask

  task automatic quiesce();
    wr(A_CTRL, 32'h0);
    for (int i = 0; i < 6; i++) idle(A_STATUS);
    wr(A_STATUS, 32'h1);
  endtask

  initial begin
    int first, highs, rises, p, period, cur, prev;
    logic prev_intr;
    int exp_q[$];

    // ---- reset state ----
    m_reset();
    #1 RST = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rst_intr", INTR, 32'h0);
    rd_want("rst_ctrl",   A_CTRL,   32'h0);
    rd_want("rst_reload", A_RELOAD, 32'h0);
    rd_want("rst_count",  A_COUNT,  32'h0);
    rd_want("rst_status", A_STATUS, 32'h0);
    @(negedge clk);
    RST = 1'b0;
    idle(A_CTRL);

    // ---- one-shot: COUNT=5, CTRL=EN|IE, P=0 ----
    wr(A_COUNT, 32'd5);
    wr(A_CTRL, 32'h5);
    first = -1; highs = 0;
    for (int k = 1; k <= 20; k++) begin
      idle(A_COUNT);
      if (INTR) begin
        highs++;
        if (first < 0) begin
          first = k;
          rd_want("os_exp", A_STATUS, 32'h1);
        end
      end
    end
    check("os_edge", first, 32'd5);
    check("os_width", highs, ICYC);
    rd_want("os_count", A_COUNT, 32'h0);

    // ---- periodic with prescale: RELOAD=3, COUNT=3, CTRL=0x27 ----
    quiesce();
    wr(A_RELOAD, 32'd3);
    wr(A_COUNT, 32'd3);
    wr(A_CTRL, 32'h27);
    p = PS_EN ? 2 : 0;
    period = 3 * (p + 1);
    prev = 3;
    exp_q.delete();
    for (int k = 1; k <= 40; k++) begin
      idle(A_COUNT);
      cur = int'(IOBUS_IN);
      if (k < period) check("per_count", cur, 32'(3 - k / (p + 1)));
      if (prev == 1 && cur == 3) exp_q.push_back(k);
      prev = cur;
    end
    check("per_n", exp_q.size(), 32'(40 / period));
    foreach (exp_q[j]) check("per_edge", exp_q[j], 32'(period * (j + 1)));
    rd_want("ctrl_rb", A_CTRL, PS_EN ? 32'h27 : 32'h7);

    // ---- collision: COUNT write in the expiry cycle ----
    quiesce();
    wr(A_COUNT, 32'd3);
    wr(A_CTRL, 32'h5);
    idle(A_COUNT);
    idle(A_COUNT);
    wr(A_COUNT, 32'd10);
    check("col_intr", INTR, 32'h0);
    rd_want("col_count", A_COUNT, 32'd10);
    rd_want("col_exp", A_STATUS, 32'h0);

    // ---- collision: STATUS clear in the expiry cycle ----
    quiesce();
    wr(A_COUNT, 32'd2);
    wr(A_CTRL, 32'h5);
    idle(A_COUNT);
    wr(A_STATUS, 32'h1);
    check("clr_intr", INTR, 32'h1);
    rd_want("clr_exp", A_STATUS, 32'h1);

    // ---- enable with COUNT=0 ----
    quiesce();
    wr(A_COUNT, 32'd0);
    wr(A_CTRL, 32'h5);
    highs = 0;
    for (int k = 0; k < 100; k++) begin
      idle(A_STATUS);
      if (INTR) highs++;
    end
    check("zero_intr", highs, 32'd0);
    rd_want("zero_exp", A_STATUS, 32'h0);

    // ---- RELOAD=0 in AUTO mode: exactly one expiry ----
    quiesce();
    wr(A_RELOAD, 32'd0);
    wr(A_COUNT, 32'd2);
    wr(A_CTRL, 32'h7);
    rises = 0; prev_intr = 1'b0;
    for (int k = 0; k < 60; k++) begin
      idle(A_COUNT);
      if (INTR && !prev_intr) rises++;
      prev_intr = INTR;
    end
    check("rl0_rises", rises, 32'd1);
    rd_want("rl0_count", A_COUNT, 32'h0);

    // ---- IE=0: flag only ----
    quiesce();
    wr(A_COUNT, 32'd2);
    wr(A_CTRL, 32'h1);
    highs = 0;
    for (int k = 0; k < 20; k++) begin
      idle(A_COUNT);
      if (INTR) highs++;
    end
    check("noie_intr", highs, 32'd0);
    rd_want("noie_exp", A_STATUS, 32'h1);

    // ---- randomized traffic against the model ----
    for (int k = 0; k < 500; k++) begin
      logic [31:0] addr, data, raddr;
      logic        w;
      w     = ($urandom_range(0, 4) == 0);
      addr  = BASE + 32'({$urandom_range(0, 3), 2'b00});
      if ($urandom_range(0, 7) == 0) addr = addr + 32'h10;
      case (addr[3:2])
        2'd0:    data = {20'd0, 6'd0, 2'($urandom_range(0, 3)), 1'b0,
                         1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                         1'($urandom_range(0, 3) != 0)};
        2'd3:    data = 32'($urandom_range(0, 1));
        default: data = 32'($urandom_range(0, 7));
      endcase
      raddr = BASE + 32'({$urandom_range(0, 5), 2'b00});
      cyc(w, addr, data, raddr);
    end

    // ---- reset in the middle of an interrupt pulse ----
    quiesce();
    wr(A_COUNT, 32'd2);
    wr(A_CTRL, 32'h5);
    for (int k = 0; k < 20 && !INTR; k++) idle(A_COUNT);
    check("pulse_before_rst", INTR, 32'h1);
    #2 RST = 1'b1;
    #1;
    check("rst_async_intr", INTR, 32'h0);
    m_reset();
    rd_want("rst2_ctrl",   A_CTRL,        32'h0);
    rd_want("rst2_reload", A_RELOAD,      32'h0);
    rd_want("rst2_count",  A_COUNT,       32'h0);
    rd_want("rst2_status", A_STATUS,      32'h0);
    rd_want("rst2_outwin", BASE + 32'h10, 32'h0);
    @(negedge clk);
    RST = 1'b0;
    for (int k = 0; k < 5; k++) idle(A_CTRL);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/otter_io_timer.md
# otter_io_timer

Memory-mapped countdown timer on the OTTER I/O bus, downstream of the CPU's IOBUS port.
- Decodes CPU stores and loads in its address window.
- Counts down at a prescaled rate and reloads in periodic mode.
- Drives a stretched interrupt pulse into the CPU interrupt input.
- Returns register contents as IOBUS read data, muxed at top level with other peripherals.

## Interface
Parameters:
- BASE_ADDR, 32'h1100_D000, word-aligned base of the 16-byte register window
- INTR_CYCLES, 4, width of the INTR pulse in clocks (1..15)

Ports:
- clk  in  1  system clock (CPU clock)
- RST  in  1  reset; one clock; reset is asynchronous and active-high
- IOBUS_ADDR  in  32  CPU bus address
- IOBUS_OUT  in  32  CPU write data (rs2)
- IOBUS_WR  in  1  CPU write strobe, one cycle per store
- IOBUS_IN  out  32  read data; 0 when address is outside the window
- INTR  out  1  interrupt request to CPU

## Operation
Registers are selected by IOBUS_ADDR[3:2] when IOBUS_ADDR[31:4] == BASE_ADDR[31:4]:
- 0x0 CTRL (rw)
  - [0] EN
  - [1] AUTO (periodic)
  - [2] IE
  - [11:4] PRESCALE
  - other bits read 0
- 0x4 RELOAD (rw), 32 bit
- 0x8 COUNT
  - read returns the live count
  - write loads the count directly
- 0xC STATUS
  - [0] EXP, sticky
  - writing 1 to bit 0 clears it

State machine, state register st:
- IDLE
  - EN=0
  - counter frozen, prescaler held at 0
  - goes to RUN when EN is written 1
- RUN
  - prescaler counts 0..PRESCALE
  - a tick occurs when the prescaler equals PRESCALE, then it wraps to 0
  - each tick with COUNT>0 decrements COUNT
  - the tick taking COUNT 1->0 is the expiry event
- On expiry:
  - EXP is set
  - if IE=1, the INTR pulse starts
  - if AUTO=1, COUNT is loaded from RELOAD and st stays RUN
  - otherwise st goes to DONE
- RUN with COUNT==0 and no expiry, e.g. enabled with a zero count:
  - no event
  - stays RUN until COUNT is written nonzero
- DONE
  - counter frozen
  - a write of nonzero to COUNT returns st to RUN
  - a CTRL write with EN=0 goes to IDLE
- Any CTRL write with EN=0 goes to IDLE from every state.

Arithmetic:
- COUNT is 32-bit unsigned and never decrements below 0.
- RELOAD==0 in AUTO mode: after expiry the count is 0, so there are no further events until software writes COUNT.

## Timing
- Reset values:
  - CTRL, RELOAD, COUNT, STATUS = 0
  - st = IDLE
  - prescaler = 0
  - INTR = 0
  - pulse counter = 0
- Reset mid-pulse drops INTR in the same (asynchronous) instant.
- Writes take effect on the posedge where IOBUS_WR=1 and the address matches.
- Reads are combinational from IOBUS_ADDR with zero latency, so the value is stable for the CPU's read-capture edge.
- Period: with EN=1, PRESCALE=P, COUNT=N, and the EN write at edge 0:
  - expiry occurs at edge N*(P+1)
  - EXP and INTR are visible after that edge
- INTR is registered and stays high exactly INTR_CYCLES cycles.
- A new expiry during an active pulse restarts the pulse counter, so the pulse is extended and not doubled.
- Simultaneous events:
  - COUNT write in the expiry cycle: the write wins, the expiry is suppressed, and no EXP or INTR results.
  - STATUS clear in the expiry cycle: set wins, so EXP=1.
  - CTRL write with EN=0 in the expiry cycle: disable wins, the expiry is suppressed.
- Writes to RELOAD never disturb the running count.

## Configuration
- OTTER_TIMER_PRESCALE_EN defined:
  - PRESCALE field and prescaler counter are present, as above.
- Not defined:
  - a tick occurs every RUN cycle, equivalent to P=0.
  - CTRL[11:4] ignores writes and reads 0.
  - no prescaler flops are built.

## Structure
- A shared package otter_timer_pkg holds:
  - register offset constants (TMR_CTRL, TMR_RELOAD, TMR_COUNT, TMR_STATUS)
  - CTRL bit-index constants
  - state enum tmr_state_t {IDLE, RUN, DONE}
- One sub-module, otter_intr_stretch, holds the INTR_CYCLES pulse generator:
  - inputs: trigger
  - output: pulse
  - behaviour: restart on retrigger
- Decode, registers, prescaler and FSM stay in otter_io_timer.

## Test plan
- Reset:
  - assert RST mid-operation
  - INTR=0 immediately
  - all registers read 0
  - read at BASE_ADDR+0x8 returns 0
  - read at BASE_ADDR+0x10 returns 0
- One-shot:
  - write COUNT=5, then CTRL=0x5 (EN, IE, P=0)
  - EXP=1 and INTR high at edge 5 after the CTRL write, for 4 cycles
  - COUNT=0, st=DONE, no second pulse
- Periodic with prescale:
  - RELOAD=3, COUNT=3, CTRL=0x27 (EN, AUTO, IE, P=2)
  - INTR pulses start every 9 cycles
  - COUNT reads 3,3,3,2,… sequence
- Collision:
  - write COUNT=10 in the exact cycle COUNT goes 1->0 → no EXP, no INTR, COUNT=10
  - write STATUS=1 in an expiry cycle → EXP stays 1
- Edge cases:
  - enable with COUNT=0 → no INTR within 100 cycles
  - RELOAD=0 in AUTO mode → exactly one expiry
  - IE=0 → EXP sets but INTR stays 0
- Macro off:
  - CTRL=0x27 write reads back 0x7
  - period equals COUNT cycles
